// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and decode-side handshake bundle for fetch_unit
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, opcode,
        input  imem_rvalid, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, opcode,
        output imem_rvalid, imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencer, single-outstanding imem fetch and instruction FIFO (optional FETCH_PERF_EN counters)
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [15:0] perf_flushed
`endif
);
    localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DROP} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d, addr_q;
    logic [31:0]     word_q [FIFO_DEPTH];
    logic [31:0]     fpc_q  [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_after_pop;
    logic            pop, push, req;
    logic            redirect_pc_unused;

    assign redirect_pc_unused = ^redirect_pc[1:0];

    assign pop             = (count_q != '0) && bus.instr_ready;
    assign count_after_pop = count_q - CW'(pop);
    // Space is reserved at request time, so a response can always be pushed.
    assign req             = (state_q == FETCH) && (count_after_pop < DEPTH_C);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (req) begin
                state_d = WAIT;
                pc_d    = pc_q + 32'd4;
            end
            WAIT:  if (bus.imem_rvalid) begin
                push    = 1'b1;
                state_d = FETCH;
            end
            DROP:  if (bus.imem_rvalid) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            push = 1'b0;
            pc_d = {redirect_pc[31:2], 2'b00};
            if (state_q == WAIT)
                state_d = bus.imem_rvalid ? FETCH : DROP;
            else if (state_q == FETCH)
                state_d = req ? DROP : FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (req) addr_q <= pc_q;
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr_q] <= bus.imem_rdata;
            fpc_q[wr_ptr_q]  <= addr_q;
        end
    end

    // The address is driven from pc_q while requesting and held in addr_q until the response.
    assign bus.imem_req    = req;
    assign bus.imem_addr   = (state_q == FETCH) ? pc_q : addr_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = bus.instr_valid ? word_q[rd_ptr_q] : 32'h0;
    assign bus.instr_pc    = bus.instr_valid ? fpc_q[rd_ptr_q]  : 32'h0;
    assign bus.opcode      = bus.instr[6:0];

`ifdef FETCH_PERF_EN
    logic flush_hit;
    assign flush_hit = redirect_valid &&
                       ((count_after_pop != '0) || (state_q == WAIT) || req);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (pop)       perf_fetched <= perf_fetched + 32'd1;
            if (flush_hit) perf_flushed <= perf_flushed + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    int          total = 0;
    int          bad   = 0;
    bit          resp_on;
    int          lat;
    logic [6:0]  op_exp [4];
    logic [31:0] ra;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [15:0] perf_flushed;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .bus           (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_flushed  (perf_flushed)
`endif
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] w;
        w = a * 32'h0009_E377 + 32'h1234_5600;
        return {w[31:7], op_exp[a[3:2]]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        redirect_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1 && bus.imem_addr === addr) seen = 1'b1;
        end
        chk1(tag, seen, 1'b1);
    endtask

    // Called at a negedge; the current sample is examined first.
    task automatic watch(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_pc);
        bit got_req;
        bit got_ins;
        got_req = 1'b0;
        got_ins = 1'b0;
        for (int c = 0; c < 30 && !(got_req && got_ins); c++) begin
            if (c > 0) @(negedge clk);
            if (!got_req && bus.imem_req === 1'b1) begin
                chk({tag, "_addr"}, bus.imem_addr, exp_addr);
                got_req = 1'b1;
            end
            if (!got_ins && bus.instr_valid === 1'b1) begin
                chk({tag, "_pc"}, bus.instr_pc, exp_pc);
                chk({tag, "_instr"}, bus.instr, word_of(exp_pc));
                got_ins = 1'b1;
            end
        end
        chk1({tag, "_req_seen"}, got_req, 1'b1);
        chk1({tag, "_instr_seen"}, got_ins, 1'b1);
    endtask

    // Memory model: answers each request after lat cycles.
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (resp_on && bus.imem_req === 1'b1) begin
                ra = bus.imem_addr;
                repeat (lat) @(posedge clk);
                #1 bus.imem_rvalid = 1'b1;
                bus.imem_rdata = word_of(ra);
                @(posedge clk);
                #1 bus.imem_rvalid = 1'b0;
            end
        end
    end

    initial begin
        int n;
        int nreq;
        bit got;
        logic [31:0] exp_a [2];

        op_exp[0] = 7'b0110011;
        op_exp[1] = 7'b0100011;
        op_exp[2] = 7'b0010011;
        op_exp[3] = 7'b0000011;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        bus.instr_ready = 1'b0;
        resp_on = 1'b1;
        lat = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_req", bus.imem_req, 1'b0);
        chk ("rst_addr", bus.imem_addr, 32'h0);
        chk1("rst_valid", bus.instr_valid, 1'b0);
        chk ("rst_instr", bus.instr, 32'h0);
        chk ("rst_pc", bus.instr_pc, 32'h0);
        chk ("rst_opcode", 32'(bus.opcode), 32'h0);

        // 1: sequential fetch, 1-cycle memory
        lat = 1;
        bus.instr_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk1("t1_idle_req", bus.imem_req, 1'b0);
        @(negedge clk);
        chk1("t1_first_req", bus.imem_req, 1'b1);
        chk ("t1_first_addr", bus.imem_addr, 32'h0);
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (bus.instr_valid === 1'b1) begin
                chk("t1_pc", bus.instr_pc, 32'(n * 4));
                chk("t1_opcode", 32'(bus.opcode), 32'(op_exp[n]));
                chk("t1_instr", bus.instr, word_of(32'(n * 4)));
                n++;
            end
        end
        chk("t1_count", 32'(n), 32'd4);

        // 2: back-pressure fills the 2-entry FIFO
        bus.instr_ready = 1'b0;
        do_reset();
        nreq = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.imem_req === 1'b1) nreq++;
        end
        chk ("t2_nreq", 32'(nreq), 32'd2);
        chk1("t2_req_idle", bus.imem_req, 1'b0);
        chk1("t2_valid", bus.instr_valid, 1'b1);
        chk ("t2_head_pc", bus.instr_pc, 32'h0);
        @(posedge clk);
        #1 bus.instr_ready = 1'b1;
        n = 0;
        got = 1'b0;
        for (int c = 0; c < 30 && (n < 3 || !got); c++) begin
            @(negedge clk);
            if (!got && bus.imem_req === 1'b1) begin
                chk("t2_resume_addr", bus.imem_addr, 32'h8);
                got = 1'b1;
            end
            if (n < 3 && bus.instr_valid === 1'b1) begin
                chk("t2_pop_pc", bus.instr_pc, 32'(n * 4));
                n++;
            end
        end
        chk1("t2_resume_seen", got, 1'b1);
        chk ("t2_pops", 32'(n), 32'd3);

        // 3: redirect while waiting on a 3-cycle memory
        lat = 3;
        do_reset();
        wait_req("t3_req0", 32'h0);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk1("t3_flushed", bus.instr_valid, 1'b0);
        chk1("t3_drop_noreq", bus.imem_req, 1'b0);
        watch("t3", 32'h100, 32'h100);

        // 4: redirect coincides with response and pop
        lat = 3;
        bus.instr_ready = 1'b0;
        do_reset();
        wait_req("t4_req0", 32'h0);
        wait_req("t4_req4", 32'h4);
        repeat (3) @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        chk1("t4_rvalid", bus.imem_rvalid, 1'b1);
        chk1("t4_head_valid", bus.instr_valid, 1'b1);
        chk ("t4_head_pc", bus.instr_pc, 32'h0);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk1("t4_flushed", bus.instr_valid, 1'b0);
        watch("t4", 32'h200, 32'h200);

        // 5: PC wraps past the top of the address space
        lat = 1;
        do_reset();
        wait_req("t5_req0", 32'h0);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        exp_a[0] = 32'hFFFF_FFFC;
        exp_a[1] = 32'h0000_0000;
        n = 0;
        got = 1'b0;
        for (int c = 0; c < 20 && (n < 2 || !got); c++) begin
            @(negedge clk);
            if (n < 2 && bus.imem_req === 1'b1) begin
                chk("t5_addr", bus.imem_addr, exp_a[n]);
                n++;
            end
            if (!got && bus.instr_valid === 1'b1) begin
                chk("t5_first_pc", bus.instr_pc, 32'hFFFF_FFFC);
                got = 1'b1;
            end
        end
        chk ("t5_nreq", 32'(n), 32'd2);
        chk1("t5_instr_seen", got, 1'b1);

        // 6: reset while waiting; the late response lands in IDLE
        lat = 2;
        do_reset();
        wait_req("t6_req8", 32'h8);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk1("t6_late_rvalid", bus.imem_rvalid, 1'b1);
        chk1("t6_valid_idle", bus.instr_valid, 1'b0);
        chk1("t6_req_idle", bus.imem_req, 1'b0);
        chk ("t6_addr_idle", bus.imem_addr, 32'h0);
        @(negedge clk);
        chk1("t6_valid_fetch", bus.instr_valid, 1'b0);
        watch("t6", 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the control/decode unit. It maintains the program counter and issues word-aligned fetches to instruction memory with at most one request outstanding. Returned words are buffered in a small FIFO, and the head entry is presented with its PC and opcode field to the control unit through a valid/ready handshake. A branch/jump redirect flushes the FIFO and any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FIFO_DEPTH, 2, instruction buffer entries; legal values are 2 or 4.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
imem_req  out  1  one-cycle fetch request pulse.
imem_addr  out  32  fetch address; held stable from imem_req until imem_rvalid.
imem_rvalid  in  1  response valid; arrives 1 or more cycles after imem_req; in order.
imem_rdata  in  32  instruction word; valid when imem_rvalid=1.
redirect_valid  in  1  branch/jump taken; single-cycle pulse.
redirect_pc  in  32  new PC; bits [1:0] ignored (forced to 0).
instr_valid  out  1  FIFO head valid.
instr_ready  in  1  consumer accepts the head this cycle.
instr  out  32  head instruction word.
instr_pc  out  32  PC of the head instruction.
opcode  out  7  instr[6:0], fed to the control unit's opcode input.

Behaviour:
- Reset (rst_n=0 at the edge):
  - pc_q=RESET_PC, state=IDLE, FIFO count=0.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0.
  - instr, instr_pc and opcode are 0.
  - Reset mid-fetch abandons the outstanding request; a late imem_rvalid in IDLE is ignored.
- FSM states: IDLE, FETCH, WAIT, DROP.
  - IDLE: always goes to FETCH on the next cycle.
  - FETCH: if count<FIFO_DEPTH (count after any same-cycle pop), pulse imem_req with imem_addr=pc_q, set pc_q<=pc_q+4, and go to WAIT. Otherwise stay in FETCH with imem_req=0.
  - WAIT: on imem_rvalid, push {imem_addr, imem_rdata} and go to FETCH.
  - DROP: on imem_rvalid, discard the data and go to FETCH.
- Earliest request: the first imem_req is asserted 2 cycles after rst_n rises. Back-to-back throughput is one request per 2 cycles with 1-cycle memory.
- Latency: imem_rvalid in cycle N gives instr_valid=1 in cycle N+1 (registered FIFO).
- Handshake:
  - Pop occurs when instr_valid && instr_ready.
  - The head is stable while instr_valid=1 and instr_ready=0.
  - Push and pop in the same cycle are allowed; the count is unchanged.
  - Overflow cannot occur because space is reserved at request time.
- Redirect has priority over every other event in the same cycle:
  - Flush the FIFO (instr_valid=0 next cycle) and set pc_q<={redirect_pc[31:2],2'b00}.
  - From WAIT with imem_rvalid=0: go to DROP.
  - From WAIT with imem_rvalid=1 in the same cycle: discard the data and go to FETCH.
  - From FETCH: cancel the request only if not yet issued. If imem_req is asserted in the same cycle, go to DROP.
  - From DROP: stay in DROP.
  - A pop in the redirect cycle is still counted as accepted by the consumer.
- Wrap-around: pc_q wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). FIFO pointers wrap modulo FIFO_DEPTH.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds output ports perf_fetched[31:0] and perf_flushed[15:0], both reset to 0 and wrapping.
  - perf_fetched increments on each instruction pop.
  - perf_flushed increments on each redirect cycle that discards at least one FIFO entry or an in-flight fetch.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset with RESET_PC=0 and a 1-cycle memory, instr_ready=1 -> imem_addr sequence 0,4,8,C; opcode follows returned words (0110011, 0100011, 0010011, 0000011); instr_pc matches each address.
2. instr_ready=0 for 10 cycles, FIFO_DEPTH=2 -> exactly 2 requests issued, then imem_req stays 0 and the head holds PC 0. Raising ready -> pops and fetch resumes at PC 8.
3. Redirect to 32'h0000_0103 while in WAIT with a 3-cycle memory -> stale response discarded, FIFO empty, next imem_addr=32'h100, first delivered instr_pc=32'h100.
4. Redirect in the same cycle as imem_rvalid and a pop -> data dropped, pop counted, next fetch from redirect_pc.
5. redirect_pc=32'hFFFF_FFFC -> following fetch addresses are FFFFFFFC, then 00000000.
6. Assert rst_n=0 while in WAIT, then rvalid arrives -> ignored; instr_valid stays 0 and the first post-reset imem_addr=RESET_PC.
